// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus: Control word layout, transfer-state
// and size encodings, master FSM states and the beat address increment.
// No ports; imported by the bus interface, the master and its sub-module.
package bus_pkg;

  localparam int CONTROL_WIDTH = 9;

  // Control word field positions
  localparam int CTRL_STATE_HI = 8;
  localparam int CTRL_STATE_LO = 7;
  localparam int CTRL_BURST_HI = 6;
  localparam int CTRL_BURST_LO = 3;
  localparam int CTRL_SIZE_HI  = 2;
  localparam int CTRL_SIZE_LO  = 1;
  localparam int CTRL_WRITE    = 0;

  // Control state field encodings (BUSY is reserved, never driven)
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  // Beat size encodings
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HW   = 2'b01;
  localparam logic [1:0] SIZE_FW   = 2'b10;
  localparam logic [1:0] SIZE_DW   = 2'b11;

  // Master FSM states; the plain constants are what the state register uses
  typedef enum logic [0:0] {
    FSM_IDLE = 1'b0,
    FSM_XFER = 1'b1
  } fsm_e;

  localparam logic [0:0] ST_IDLE = FSM_IDLE;
  localparam logic [0:0] ST_XFER = FSM_XFER;

  // Bytes covered by one beat of the given size
  function automatic logic [3:0] beat_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/bus_master_ctrl_if.sv
// Master-to-slave memory bus bundle.
// Ports: Control/Addr/WData/En driven by the master; Ready/RData by the slave.
// Modports: master (initiator side), slave (memory controller side).
interface bus_master_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  import bus_pkg::*;

  logic [CONTROL_WIDTH-1:0] Control;
  logic [ADDR_WIDTH-1:0]    Addr;
  logic [DATA_WIDTH-1:0]    WData;
  logic                     En;
  logic                     Ready;
  logic [DATA_WIDTH-1:0]    RData;

  modport master (output Control, Addr, WData, En, input Ready, RData);
  modport slave  (input Control, Addr, WData, En, output Ready, RData);

endinterface

// File: rtl/bus_beat_counter.sv
// Remaining-beats down counter for a burst; load wins over decrement.
// Latency: count updates one edge after load/dec; zero flag is combinational.
// Ports: clk, clr_n (sync active-low clear), load/load_val, dec, zero.
module bus_beat_counter (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/bus_master_ctrl.sv
// Bus initiator: turns a single/burst request into per-beat Control/Addr/WData/En.
// Latency: Ack and first beat one edge after Req in IDLE; Done/RValid one edge after accept.
// Backpressure: beats hold until slave Ready; optional TIMEOUT_EN aborts long stalls with Err.
// Ports: Clk, Rst (sync active-low), requester Req*/Ack/Busy/BeatDone/RDataOut/RValid/Done/Err,
//        bus (master modport of bus_master_ctrl_if).
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Req,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic                  ReqWrite,
  input  logic [1:0]            ReqSize,
  input  logic [3:0]            ReqBurst,
  input  logic [DATA_WIDTH-1:0] ReqWData,
  output logic                  Ack,
  output logic                  Busy,
  output logic                  BeatDone,
  output logic [DATA_WIDTH-1:0] RDataOut,
  output logic                  RValid,
  output logic                  Done,
  output logic                  Err,
  bus_master_ctrl_if.master     bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [0:0]            state;
  logic [1:0]            trans;
  logic [3:0]            burst;
  logic [1:0]            size;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  en;
  logic                  last_beat;
  logic                  in_xfer;
  logic                  timeout;

  assign in_xfer  = (state == ST_XFER);
  assign BeatDone = in_xfer & bus.Ready;

  bus_beat_counter u_beat_cnt (
    .clk      (Clk),
    .clr_n    (Rst),
    .load     ((state == ST_IDLE) & Req),
    .load_val (ReqBurst),
    .dec      (BeatDone),
    .zero     (last_beat)
  );

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] stall_cnt;
  logic          err_q;

  // stall_cnt holds the stalled cycles already seen, so the current stalled
  // cycle is the TIMEOUT_CYCLES-th one when it equals TIMEOUT_CYCLES-1.
  assign timeout = in_xfer & ~bus.Ready & (stall_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (!Rst || !in_xfer || bus.Ready || timeout) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + TW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
    end
  end

  assign Err = err_q;
`else
  assign timeout = 1'b0;
  assign Err     = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= ST_IDLE;
      trans    <= TRANS_IDLE;
      burst    <= 4'd0;
      size     <= SIZE_BYTE;
      write    <= 1'b0;
      addr     <= '0;
      en       <= 1'b0;
      Busy     <= 1'b0;
      Ack      <= 1'b0;
      RDataOut <= '0;
      RValid   <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Ack    <= 1'b0;
      RValid <= 1'b0;
      Done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Ready is deliberately ignored here
          if (Req) begin
            state <= ST_XFER;
            trans <= TRANS_NONSEQ;
            burst <= ReqBurst;
            size  <= ReqSize;
            write <= ReqWrite;
            addr  <= ReqAddr;
            en    <= 1'b1;
            Busy  <= 1'b1;
            Ack   <= 1'b1;
          end
        end
        default: begin
          if (BeatDone) begin
            if (!write) begin
              RDataOut <= bus.RData;
              RValid   <= 1'b1;
            end
            if (!last_beat) begin
              addr  <= addr + ADDR_WIDTH'(beat_bytes(size));
              trans <= TRANS_SEQ;
            end else begin
              // Clearing the latched fields makes the whole Control word 0
              state <= ST_IDLE;
              trans <= TRANS_IDLE;
              burst <= 4'd0;
              size  <= SIZE_BYTE;
              write <= 1'b0;
              en    <= 1'b0;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end
          end else if (timeout) begin
            state <= ST_IDLE;
            trans <= TRANS_IDLE;
            burst <= 4'd0;
            size  <= SIZE_BYTE;
            write <= 1'b0;
            en    <= 1'b0;
            Busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.Control = {trans, burst, size, write};
  assign bus.Addr    = addr;
  assign bus.En      = en;
  assign bus.WData   = (in_xfer && write) ? ReqWData : '0;

endmodule
